// File: rtl/common_p.sv
// Shared clock-domain bundle: one clock, its enable qualifier and a
// synchronous active-high reset.
package common_p;

   typedef struct packed {
      logic clk;
      logic clk_en;
      logic sync_rst;
   } clk_dom;

endpackage

// File: rtl/flag_bank_pkg.sv
// flag_bank_p: command bundle, per-channel action encoding and the
// clear > set > toggle > expiry > hold priority resolver.
package flag_bank_p;

   typedef struct packed {
      logic clear;
      logic set;
      logic toggle;
   } flag_cmd_t;

   typedef enum logic [2:0] {
      HOLD,
      SET_LOAD,
      CLEAR,
      EXPIRE,
      DECREMENT
   } flag_act_t;

   // timer_one: timer == 1, timer_nz: timer != 0
   function automatic flag_act_t flag_resolve(
      input flag_cmd_t cmd,
      input logic      state,
      input logic      timer_one,
      input logic      timer_nz
   );
      flag_act_t act;
      if (cmd.clear)
         act = CLEAR;
      else if (cmd.set)
         act = SET_LOAD;
      else if (cmd.toggle)
         act = state ? CLEAR : SET_LOAD;
      else if (state && timer_one)
         act = EXPIRE;
      else if (state && timer_nz)
         act = DECREMENT;
      else
         act = HOLD;
      return act;
   endfunction

endpackage

// File: rtl/flag_bank_if.sv
// Command/status bundle for a flag_bank instance. The master drives
// commands and hold counts; the slave returns flag state and events.
interface flag_bank_if #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned HOLD_W   = 8
);
   logic [CHANNELS-1:0]        clear_en;
   logic [CHANNELS-1:0]        set_en;
   logic [CHANNELS-1:0]        toggle_en;
   logic [CHANNELS*HOLD_W-1:0] hold;
   logic [CHANNELS-1:0]        state;
   logic [CHANNELS-1:0]        rise;
   logic [CHANNELS-1:0]        fall;
   logic                       any;

   modport master (
      output clear_en, set_en, toggle_en, hold,
      input  state, rise, fall, any
   );

   modport slave (
      input  clear_en, set_en, toggle_en, hold,
      output state, rise, fall, any
   );
endinterface

// File: rtl/flag_bank_channel.sv
// flag_channel: one flag with its auto-clear hold timer and, when
// FLAG_BANK_EDGE_OUT_EN is defined, registered rise/fall pulses.
module flag_channel
   import common_p::*;
   import flag_bank_p::*;
#(
   parameter int unsigned HOLD_W = 8
) (
   input  clk_dom            i_clk_dom,
   input  logic              i_clear,
   input  logic              i_set,
   input  logic              i_toggle,
   input  logic [HOLD_W-1:0] i_hold,
   output logic              o_state,
   output logic              o_rise,
   output logic              o_fall
);

   logic              w_clk;
   logic              w_en;
   logic              w_rst;
   flag_cmd_t         w_cmd;
   flag_act_t         w_act;
   logic              w_state_nxt;
   logic [HOLD_W-1:0] w_timer_nxt;
   logic              r_state;
   logic [HOLD_W-1:0] r_timer;

   assign w_clk = i_clk_dom.clk;
   assign w_en  = i_clk_dom.clk_en;
   assign w_rst = i_clk_dom.sync_rst;

   // resolve this cycle's action and the resulting state/timer
   always_comb begin
      w_cmd       = '{clear: i_clear, set: i_set, toggle: i_toggle};
      w_act       = flag_resolve(w_cmd, r_state, r_timer == HOLD_W'(1),
                                 r_timer != '0);
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (w_act)
         SET_LOAD: begin
            w_state_nxt = 1'b1;
            w_timer_nxt = i_hold;
         end
         CLEAR, EXPIRE: begin
            w_state_nxt = 1'b0;
            w_timer_nxt = '0;
         end
         DECREMENT: w_timer_nxt = r_timer - HOLD_W'(1);
         default: ;
      endcase
   end

   // flag and timer registers, advanced only on enabled edges
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state <= 1'b0;
         r_timer <= '0;
      end else if (w_en) begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   assign o_state = r_state;

`ifdef FLAG_BANK_EDGE_OUT_EN
   logic r_rise;
   logic r_fall;

   // edge pulses held for one enabled period; reset clears without a fall
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else if (w_en) begin
         r_rise <= w_state_nxt & ~r_state;
         r_fall <= ~w_state_nxt & r_state;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/flag_bank.sv
// flag_bank: CHANNELS independent set/clear/toggle flags with auto-clear
// hold timers and an any-flag summary. Optional feature macro:
// FLAG_BANK_EDGE_OUT_EN (rise_o/fall_o pulses; tied to 0 when undefined).
module flag_bank
   import common_p::*;
#(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned HOLD_W   = 8
) (
   input  clk_dom                     clk_dom_i,
   input  logic [CHANNELS-1:0]        clear_en,
   input  logic [CHANNELS-1:0]        set_en,
   input  logic [CHANNELS-1:0]        toggle_en,
   input  logic [CHANNELS*HOLD_W-1:0] hold_i,
   output logic [CHANNELS-1:0]        state_o,
   output logic [CHANNELS-1:0]        rise_o,
   output logic [CHANNELS-1:0]        fall_o,
   output logic                       any_o
);

   logic [CHANNELS-1:0] w_state;
   logic [CHANNELS-1:0] w_rise;
   logic [CHANNELS-1:0] w_fall;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      flag_channel #(
         .HOLD_W (HOLD_W)
      ) u_ch (
         .i_clk_dom (clk_dom_i),
         .i_clear   (clear_en[g]),
         .i_set     (set_en[g]),
         .i_toggle  (toggle_en[g]),
         .i_hold    (hold_i[g*HOLD_W +: HOLD_W]),
         .o_state   (w_state[g]),
         .o_rise    (w_rise[g]),
         .o_fall    (w_fall[g])
      );
   end

   assign state_o = w_state;
   assign rise_o  = w_rise;
   assign fall_o  = w_fall;
   assign any_o   = |w_state;

endmodule

// File: tb/tb_flag_bank.sv
// Self-checking bench for flag_bank: directed scenarios followed by random
// traffic, all compared against a deadline-based reference model.
module tb_flag_bank;
   import common_p::*;

   localparam int unsigned CH = 8;
   localparam int unsigned HW = 8;
`ifdef FLAG_BANK_EDGE_OUT_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic   clk;
   logic   en;
   logic   rst;
   clk_dom cd;

   flag_bank_if #(.CHANNELS(CH), .HOLD_W(HW)) bus ();

   assign cd = '{clk: clk, clk_en: en, sync_rst: rst};

   flag_bank #(
      .CHANNELS (CH),
      .HOLD_W   (HW)
   ) dut (
      .clk_dom_i (cd),
      .clear_en  (bus.clear_en),
      .set_en    (bus.set_en),
      .toggle_en (bus.toggle_en),
      .hold_i    (bus.hold),
      .state_o   (bus.state),
      .rise_o    (bus.rise),
      .fall_o    (bus.fall),
      .any_o     (bus.any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: a flag is on/off with an absolute expiry deadline
   // counted in enabled edges (0 = never expires)
   logic [CH-1:0]   m_state = '0;
   logic [CH-1:0]   m_rise  = '0;
   logic [CH-1:0]   m_fall  = '0;
   longint unsigned m_dead[CH];
   longint unsigned edge_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [CH-1:0] nw;
      if (rst) begin
         m_state = '0;
         m_rise  = '0;
         m_fall  = '0;
      end else if (en) begin
         edge_cnt++;
         nw = m_state;
         for (int n = 0; n < CH; n++) begin
            logic [HW-1:0] h;
            h = bus.hold[n*HW +: HW];
            if (bus.clear_en[n])
               nw[n] = 1'b0;
            else if (bus.set_en[n] || (bus.toggle_en[n] && !m_state[n])) begin
               nw[n]     = 1'b1;
               m_dead[n] = (h == '0) ? 64'd0 : edge_cnt + 64'(h);
            end else if (bus.toggle_en[n])
               nw[n] = 1'b0;
            else if (m_state[n] && m_dead[n] != 0 && m_dead[n] == edge_cnt)
               nw[n] = 1'b0;
         end
         m_rise  = EDGE ? (nw & ~m_state) : '0;
         m_fall  = EDGE ? (~nw & m_state) : '0;
         m_state = nw;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("state", 64'(bus.state), 64'(m_state));
      chk("rise",  64'(bus.rise),  64'(m_rise));
      chk("fall",  64'(bus.fall),  64'(m_fall));
      chk("any",   64'(bus.any),   64'(|m_state));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_hold(input int n, input int v);
      bus.hold[n*HW +: HW] = HW'(v);
   endtask

   task automatic clear_all();
      bus.clear_en = '1;
      step();
      bus.clear_en = '0;
   endtask

   int            cnt;
   int            rises;
   logic [CH-1:0] sv_state;
   logic [CH-1:0] sv_rise;
   logic [CH-1:0] sv_fall;

   initial begin
      for (int n = 0; n < CH; n++) m_dead[n] = 0;
      en            = 1'b1;
      rst           = 1'b1;
      bus.clear_en  = '0;
      bus.set_en    = '1;
      bus.toggle_en = '0;
      bus.hold      = '0;

      // reset dominates commands
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_state", 64'(bus.state), 64'd0);
         chk("rst_rise",  64'(bus.rise),  64'd0);
         chk("rst_any",   64'(bus.any),   64'd0);
      end
      rst        = 1'b0;
      bus.set_en = 8'h01;
      step();
      chk("first_state", 64'(bus.state), 64'h01);
      chk("first_rise",  64'(bus.rise),  64'(EDGE));
      bus.set_en = '0;
      step();
      chk("first_rise_end", 64'(bus.rise), 64'd0);
      clear_all();

      // priority: clear beats set/toggle on ch2; set beats toggle on ch3
      bus.set_en = 8'h04;
      step();
      bus.clear_en  = 8'h04;
      bus.set_en    = 8'h0C;
      bus.toggle_en = 8'h0C;
      step();
      chk("prio_ch2", 64'(bus.state[2]), 64'd0);
      chk("prio_fall2", 64'(bus.fall[2]), 64'(EDGE));
      chk("prio_ch3", 64'(bus.state[3]), 64'd1);
      bus.clear_en  = '0;
      bus.set_en    = '0;
      bus.toggle_en = '0;
      step();
      clear_all();

      // auto-clear with clk_en alternating: H=5 -> 10 clocks high
      set_hold(0, 5);
      bus.set_en = 8'h01;
      step();
      bus.set_en = '0;
      cnt = 0;
      if (bus.state[0]) cnt++;
      for (int i = 0; i < 20; i++) begin
         en = i[0];
         step();
         if (bus.state[0]) cnt++;
      end
      en = 1'b1;
      chk("autoclr_len", 64'(cnt), 64'd10);

      // retrigger: H=4, set at edges 0 and 2 -> high through edge 5
      set_hold(1, 4);
      bus.set_en = 8'h02;
      step();
      rises = 0;
      cnt   = 0;
      if (bus.rise[1])  rises++;
      if (bus.state[1]) cnt++;
      bus.set_en = '0;
      for (int i = 1; i < 12; i++) begin
         bus.set_en = (i == 2) ? 8'h02 : 8'h00;
         step();
         if (bus.rise[1])  rises++;
         if (bus.state[1]) cnt++;
      end
      bus.set_en = '0;
      chk("retrig_len",   64'(cnt),   64'd6);
      chk("retrig_rises", 64'(rises), 64'(EDGE));

      // expiry collides with toggle: single fall
      set_hold(4, 3);
      bus.set_en = 8'h10;
      step();
      bus.set_en = '0;
      idle(2);
      bus.toggle_en = 8'h10;
      step();
      bus.toggle_en = '0;
      chk("exp_tog_state", 64'(bus.state[4]), 64'd0);
      chk("exp_tog_fall",  64'(bus.fall[4]),  64'(EDGE));
      step();
      chk("exp_tog_fall_end", 64'(bus.fall[4]), 64'd0);

      // expiry collides with set: set wins and reloads
      bus.set_en = 8'h10;
      step();
      bus.set_en = '0;
      idle(2);
      bus.set_en = 8'h10;
      step();
      bus.set_en = '0;
      chk("exp_set_state", 64'(bus.state[4]), 64'd1);
      chk("exp_set_fall",  64'(bus.fall[4]),  64'd0);
      idle(2);
      chk("exp_set_hold", 64'(bus.state[4]), 64'd1);
      step();
      chk("exp_set_done", 64'(bus.state[4]), 64'd0);

      // clk_en low freezes everything despite commands
      bus.set_en = 8'hA5;
      step();
      bus.set_en = '0;
      sv_state = bus.state;
      sv_rise  = bus.rise;
      sv_fall  = bus.fall;
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.clear_en  = CH'($urandom);
         bus.set_en    = CH'($urandom);
         bus.toggle_en = CH'($urandom);
         step();
         chk("en0_state", 64'(bus.state), 64'(sv_state));
         chk("en0_rise",  64'(bus.rise),  64'(sv_rise));
         chk("en0_fall",  64'(bus.fall),  64'(sv_fall));
      end
      bus.clear_en  = '0;
      bus.set_en    = '0;
      bus.toggle_en = '0;
      en = 1'b1;
      idle(6);

      // reset mid-hold discards the timer
      clear_all();
      bus.set_en = 8'h01;
      step();
      bus.set_en = '0;
      idle(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(8);
      chk("rst_mid_hold", 64'(bus.state[0]), 64'd0);

      // random traffic
      for (int n = 0; n < CH; n++) set_hold(n, int'($urandom_range(6)));
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(99) == 0);
         en  = ($urandom_range(9) < 7);
         for (int n = 0; n < CH; n++) begin
            bus.clear_en[n]  = ($urandom_range(11) == 0);
            bus.set_en[n]    = ($urandom_range(7) == 0);
            bus.toggle_en[n] = ($urandom_range(7) == 0);
         end
         if ($urandom_range(19) == 0)
            set_hold(int'($urandom_range(CH-1)), int'($urandom_range(6)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
